turtle_lane_ctrl: RTL and testbench
===================================

TURTLE_LANE_CTRL -- requirements
Module: turtle_lane_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM = 20, number of turtle slots.
- H_RES = 640, horizontal wrap span in pixels.
- ANIM_DIV = 8, frames per animation step.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 frame_start  input  1  single-cycle pulse at start of vertical blanking.
REQ-005 cfg_we  input  1  configuration write strobe.
REQ-006 cfg_slot  input  5  target slot index; values >= NUM are ignored.
REQ-007 cfg_sel  input  2  field select: 0 = x, 1 = y, 2 = attr; 3 is ignored.
REQ-008 cfg_wdata  input  11  write data; attr layout is {en[8], dir[7], speed[6:3], color[2:1], unused[0]}.
REQ-009 x_all  output  NUM*11  packed sprite x origins, slot k at [11k+10:11k].
REQ-010 y_all  output  NUM*11  packed sprite y origins, same packing.
REQ-011 ctrl_all  output  NUM*4  packed sprite ctrl, slot k = {color[1:0], anim_id[1:0]}.
REQ-012 busy  output  1  high while the slot scan is in progress.
REQ-013 done  output  1  one-cycle pulse at the end of each scan.
REQ-014 overrun  output  1  sticky flag: frame_start arrived while not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SCAN and DONE.
REQ-016 Transition IDLE->SCAN SHALL occur on frame_start, clearing slot_idx to 0.
REQ-017 In SCAN, one slot (slot_idx) SHALL be updated per cycle, then slot_idx increments.
REQ-018 SCAN->DONE SHALL occur after slot_idx = NUM-1 is processed; DONE->IDLE is unconditional.
REQ-019 busy SHALL be high in SCAN and DONE; done SHALL be high only in DONE.
REQ-020 Timing: frame_start sampled at edge N SHALL give busy high from N to N+NUM+1 (21 cycles), with done high in the final cycle.
REQ-021 Enabled slot, dir = 0 (right): nx = x + speed; if nx >= H_RES then nx = nx - H_RES.
REQ-022 Enabled slot, dir = 1 (left): if x < speed then nx = x + H_RES - speed, else nx = x - speed.
REQ-023 Arithmetic for REQ-021/022 SHALL use 12-bit unsigned intermediates, result truncated to 11 bits.
REQ-024 Disabled slots (en = 0) SHALL keep their x unchanged during the scan.
REQ-025 y_all for a disabled slot SHALL read 11'h7FF (off-screen); an enabled slot outputs its stored y.
REQ-026 anim_id is a single 2-bit value shared by all slots.
REQ-027 In DONE, frame_cnt SHALL increment; at ANIM_DIV-1 it wraps to 0 and anim_id increments mod 4.
REQ-028 A cfg write SHALL take effect at the next edge in any state.
REQ-029 If a cfg write to x targets the slot being scanned in the same cycle, the cfg write SHALL win and the motion update is dropped.
REQ-030 frame_start in SCAN or DONE SHALL be ignored for sequencing and SHALL set overrun.
REQ-031 overrun SHALL clear only on reset.
REQ-032 All outputs SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-033 Reset SHALL place the FSM in IDLE and clear slot_idx, frame_cnt, anim_id, busy, done and overrun.
REQ-034 Reset SHALL clear every slot's x, y and attr to 0, so y_all reads all 11'h7FF.
REQ-035 Reset asserted mid-scan SHALL abort the scan at the next edge with no done pulse; partially updated slots are discarded by the clear.
REQ-036 Reset SHALL take priority over cfg_we and frame_start in the same cycle.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- Slot 3: x = 100, en = 1, dir = 0, speed = 5; one frame_start -> x3 = 105; busy high for 21 cycles; done a single pulse.
- Slot 0: x = 637, dir = 0, speed = 5 -> x0 = 2 after one scan (right wrap).
- Slot 7: x = 3, dir = 1, speed = 5 -> x7 = 638 (left wrap); slot 8 disabled with x = 50 -> stays 50, y8 reads 7FF.
- 8 frame_starts spaced 30 cycles apart -> anim_id 0 -> 1, ctrl_all slot k low bits = 1; 32 frames -> anim_id back to 0.
- frame_start repeated 5 cycles after the first -> overrun = 1, only one scan, one done pulse; overrun persists until reset.
- cfg write of x = 200 to slot 4 in the cycle slot 4 is scanned -> x4 = 200; reset at scan cycle 10 -> next cycle busy = 0, all x = 0, no done pulse.

Source files
------------

// File: rtl/turtle_lane_ctrl_if.sv
// Bundle of configuration, frame-sync and sprite-output signals for turtle_lane_ctrl.
// The master side drives frame sync and config writes; the slave side returns sprite data.
interface turtle_lane_ctrl_if #(
  parameter int NUM = 20
);
  logic                frame_start;
  logic                cfg_we;
  logic [4:0]          cfg_slot;
  logic [1:0]          cfg_sel;
  logic [10:0]         cfg_wdata;
  logic [NUM*11-1:0]   x_all;
  logic [NUM*11-1:0]   y_all;
  logic [NUM*4-1:0]    ctrl_all;
  logic                busy;
  logic                done;
  logic                overrun;

  modport master (
    output frame_start, cfg_we, cfg_slot, cfg_sel, cfg_wdata,
    input  x_all, y_all, ctrl_all, busy, done, overrun
  );

  modport slave (
    input  frame_start, cfg_we, cfg_slot, cfg_sel, cfg_wdata,
    output x_all, y_all, ctrl_all, busy, done, overrun
  );
endinterface

// File: rtl/turtle_lane_ctrl.sv
// Per-frame motion sequencer for a lane of turtle sprites: during blanking it advances one
// slot per cycle with horizontal wrap, and steps a shared animation frame every ANIM_DIV frames.
module turtle_lane_ctrl #(
  parameter int NUM      = 20,
  parameter int H_RES    = 640,
  parameter int ANIM_DIV = 8
) (
  input logic               clk,
  input logic               reset,
  turtle_lane_ctrl_if.slave bus
);
  localparam int FC_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [5:0] NUM6 = 6'(NUM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [4:0]           slot_idx_r;
  logic [FC_W-1:0]      frame_cnt_r;
  logic [1:0]           anim_r;
  logic [1:0]           anim_nxt;
  logic                 busy_r;
  logic                 done_r;
  logic                 overrun_r;
  logic                 cfg_hit_s;

  logic [NUM-1:0][10:0] x_r;
  logic [NUM-1:0][10:0] y_r;
  logic [NUM-1:0][8:0]  attr_r;
  logic [NUM-1:0][10:0] x_nxt;
  logic [NUM-1:0][10:0] y_nxt;
  logic [NUM-1:0][8:0]  attr_nxt;
  logic [NUM-1:0][10:0] y_disp_r;
  logic [NUM-1:0][3:0]  ctrl_r;

  // Wrapped horizontal step; 12-bit intermediates keep x + speed and x + H_RES exact.
  function automatic logic [10:0] step_x(input logic [10:0] x, input logic left,
                                         input logic [3:0] spd);
    logic [11:0] t;
    if (!left) begin
      t = {1'b0, x} + {8'd0, spd};
      if (t >= 12'(H_RES)) begin
        t = t - 12'(H_RES);
      end else begin
        t = t;
      end
    end else if ({1'b0, x} < {8'd0, spd}) begin
      t = {1'b0, x} + 12'(H_RES) - {8'd0, spd};
    end else begin
      t = {1'b0, x} - {8'd0, spd};
    end
    return t[10:0];
  endfunction

  assign cfg_hit_s = bus.cfg_we && ({1'b0, bus.cfg_slot} < NUM6);

  // Shared animation id advances on the last frame of each ANIM_DIV group.
  always_comb begin
    anim_nxt = anim_r;
    if ((state_r == S_DONE) && (frame_cnt_r == FC_W'(ANIM_DIV - 1))) begin
      anim_nxt = anim_r + 2'd1;
    end else begin
      anim_nxt = anim_r;
    end
  end

  // Next slot contents: motion for the scanned slot first, then config writes override it.
  always_comb begin
    x_nxt    = x_r;
    y_nxt    = y_r;
    attr_nxt = attr_r;
    if ((state_r == S_SCAN) && attr_r[slot_idx_r][8]) begin
      x_nxt[slot_idx_r] = step_x(x_r[slot_idx_r], attr_r[slot_idx_r][7],
                                 attr_r[slot_idx_r][6:3]);
    end else begin
      x_nxt[slot_idx_r] = x_r[slot_idx_r];
    end
    if (cfg_hit_s) begin
      case (bus.cfg_sel)
        2'd0:    x_nxt[bus.cfg_slot]    = bus.cfg_wdata;
        2'd1:    y_nxt[bus.cfg_slot]    = bus.cfg_wdata;
        2'd2:    attr_nxt[bus.cfg_slot] = bus.cfg_wdata[8:0];
        default: attr_nxt[bus.cfg_slot] = attr_r[bus.cfg_slot];
      endcase
    end else begin
      attr_nxt = attr_nxt;
    end
  end

  // Sequencer: idle -> one-slot-per-cycle scan -> single done cycle; tracks overrun and frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      slot_idx_r  <= 5'd0;
      frame_cnt_r <= '0;
      anim_r      <= 2'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (bus.frame_start && (state_r != S_IDLE)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.frame_start) begin
            state_r    <= S_SCAN;
            slot_idx_r <= 5'd0;
            busy_r     <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_SCAN: begin
          busy_r <= 1'b1;
          if (slot_idx_r == 5'(NUM - 1)) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end else begin
            slot_idx_r <= slot_idx_r + 5'd1;
            done_r     <= 1'b0;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          anim_r  <= anim_nxt;
          if (frame_cnt_r == FC_W'(ANIM_DIV - 1)) begin
            frame_cnt_r <= '0;
          end else begin
            frame_cnt_r <= frame_cnt_r + FC_W'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Slot storage plus registered display copies; disabled slots park y off-screen.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r      <= '0;
      y_r      <= '0;
      attr_r   <= '0;
      y_disp_r <= '1;
      ctrl_r   <= '0;
    end else begin
      x_r    <= x_nxt;
      y_r    <= y_nxt;
      attr_r <= attr_nxt;
      for (int k = 0; k < NUM; k++) begin
        y_disp_r[k] <= attr_nxt[k][8] ? y_nxt[k] : 11'h7FF;
        ctrl_r[k]   <= {attr_nxt[k][2:1], anim_nxt};
      end
    end
  end

  assign bus.x_all    = x_r;
  assign bus.y_all    = y_disp_r;
  assign bus.ctrl_all = ctrl_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.overrun  = overrun_r;
endmodule

// File: tb/tb_turtle_lane_ctrl.sv
// Randomized bench for turtle_lane_ctrl: a time-based reference model of the lane is compared
// every cycle, with directed scenarios pinning specific values.
module tb_turtle_lane_ctrl;
  localparam int NUM      = 20;
  localparam int H_RES    = 640;
  localparam int ANIM_DIV = 8;

  logic clk;
  logic reset;
  turtle_lane_ctrl_if #(.NUM(NUM)) ifc ();

  turtle_lane_ctrl #(.NUM(NUM), .H_RES(H_RES), .ANIM_DIV(ANIM_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: slot contents plus scan start time; everything else derives from time.
  int       mx [NUM];
  int       my [NUM];
  logic [8:0] mattr [NUM];
  int       t_now = 0;
  int       start_t = 0;
  bit       active = 1'b0;
  bit       was_active;
  int       frames = 0;
  bit       m_ov = 1'b0;
  int       ph;
  int       ks;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int move_x(input int x, input bit left, input int s);
    int n;
    if (!left) begin
      n = x + s;
      if (n >= H_RES) n = n - H_RES;
    end else if (x < s) begin
      n = x + H_RES - s;
    end else begin
      n = x - s;
    end
    return n % 2048;
  endfunction

  always @(posedge clk) begin
    t_now++;
    if (reset) begin
      for (int k = 0; k < NUM; k++) begin
        mx[k] = 0; my[k] = 0; mattr[k] = 9'd0;
      end
      active = 1'b0; frames = 0; m_ov = 1'b0;
    end else begin
      was_active = active;
      if (active) begin
        ph = t_now - start_t;
        if (ph >= 1 && ph <= NUM) begin
          ks = ph - 1;
          if (mattr[ks][8]) mx[ks] = move_x(mx[ks], mattr[ks][7], int'(mattr[ks][6:3]));
        end
        if (ph == NUM + 1) begin
          frames++;
          active = 1'b0;
        end
      end
      if (ifc.frame_start) begin
        if (was_active) m_ov = 1'b1;
        else begin
          active = 1'b1;
          start_t = t_now;
        end
      end
      if (ifc.cfg_we && ifc.cfg_slot < NUM) begin
        case (ifc.cfg_sel)
          2'd0: mx[ifc.cfg_slot] = int'(ifc.cfg_wdata);
          2'd1: my[ifc.cfg_slot] = int'(ifc.cfg_wdata);
          2'd2: mattr[ifc.cfg_slot] = ifc.cfg_wdata[8:0];
          default: ;
        endcase
      end
    end
  end

  logic [NUM*11-1:0] ex, ey;
  logic [NUM*4-1:0]  ec;
  logic [1:0]        e_anim;

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      e_anim = 2'((frames / ANIM_DIV) % 4);
      for (int k = 0; k < NUM; k++) begin
        ex[11*k +: 11] = 11'(mx[k]);
        ey[11*k +: 11] = mattr[k][8] ? 11'(my[k]) : 11'h7FF;
        ec[4*k +: 4]   = {mattr[k][2:1], e_anim};
      end
      check("x_all", ifc.x_all, ex);
      check("y_all", ifc.y_all, ey);
      check("ctrl_all", ifc.ctrl_all, ec);
      check("busy", ifc.busy, active);
      check("done", ifc.done, active && (t_now - start_t == NUM));
      check("overrun", ifc.overrun, m_ov);
    end
  end

  function automatic int dut_x(input int k);
    return int'(ifc.x_all[11*k +: 11]);
  endfunction

  task automatic cfg_wr(input int slot, input int sel, input int data);
    ifc.cfg_we = 1'b1; ifc.cfg_slot = 5'(slot); ifc.cfg_sel = 2'(sel); ifc.cfg_wdata = 11'(data);
    @(negedge clk);
    ifc.cfg_we = 1'b0;
  endtask

  task automatic pulse_fs();
    ifc.frame_start = 1'b1;
    @(negedge clk);
    ifc.frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_cfg();
    ifc.cfg_we    = ($urandom_range(0, 3) == 0);
    ifc.cfg_slot  = 5'($urandom_range(0, 31));
    ifc.cfg_sel   = 2'($urandom_range(0, 3));
    ifc.cfg_wdata = 11'($urandom_range(0, 2047));
  endtask

  int bcnt, dcnt;
  logic [2*NUM-1:0] lb;

  initial begin
    reset = 1'b1;
    ifc.frame_start = 1'b0; ifc.cfg_we = 1'b0; ifc.cfg_slot = 5'd0;
    ifc.cfg_sel = 2'd0; ifc.cfg_wdata = 11'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_x", ifc.x_all, '0);
    check("rst_y", ifc.y_all, {NUM{11'h7FF}});
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_overrun", ifc.overrun, 1'b0);

    // Right move, right wrap, left wrap, disabled slot.
    cfg_wr(3, 0, 100); cfg_wr(3, 2, 'h12C);
    cfg_wr(0, 0, 637); cfg_wr(0, 2, 'h128);
    cfg_wr(7, 0, 3);   cfg_wr(7, 2, 'h1A8);
    cfg_wr(8, 0, 50);  cfg_wr(8, 1, 100);
    pulse_fs();
    bcnt = 0; dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.busy) bcnt++;
      if (ifc.done) dcnt++;
      @(negedge clk);
    end
    check("x3_right", dut_x(3), 105);
    check("x0_wrap", dut_x(0), 2);
    check("x7_lwrap", dut_x(7), 638);
    check("x8_dis", dut_x(8), 50);
    check("y8_dis", ifc.y_all[11*8 +: 11], 11'h7FF);
    check("busy_len", bcnt, 21);
    check("done_cnt", dcnt, 1);

    // Animation stepping under random config traffic.
    do_reset();
    for (int f = 0; f < 32; f++) begin
      pulse_fs();
      for (int c = 0; c < 29; c++) begin
        rand_cfg();
        @(negedge clk);
      end
      ifc.cfg_we = 1'b0;
      if (f == 7 || f == 31) begin
        for (int k = 0; k < NUM; k++) lb[2*k +: 2] = ifc.ctrl_all[4*k +: 2];
        check(f == 7 ? "anim_8" : "anim_32", lb, f == 7 ? {NUM{2'b01}} : {NUM{2'b00}});
      end
    end

    // Overrun: second frame_start five cycles after the first.
    do_reset();
    pulse_fs();
    bcnt = 0; dcnt = 0;
    for (int i = 0; i < 45; i++) begin
      if (ifc.busy) bcnt++;
      if (ifc.done) dcnt++;
      ifc.frame_start = (i == 4);
      @(negedge clk);
    end
    check("ovr_busy_len", bcnt, 21);
    check("ovr_done_cnt", dcnt, 1);
    check("ovr_flag", ifc.overrun, 1'b1);
    repeat (50) @(negedge clk);
    check("ovr_sticky", ifc.overrun, 1'b1);
    do_reset();
    check("ovr_cleared", ifc.overrun, 1'b0);

    // Config write to x of the slot being scanned wins over motion.
    cfg_wr(4, 0, 10); cfg_wr(4, 2, 'h118);
    pulse_fs();
    repeat (4) @(negedge clk);
    cfg_wr(4, 0, 200);
    repeat (25) @(negedge clk);
    check("x4_cfg_wins", dut_x(4), 200);

    // Reset mid-scan aborts with no done pulse.
    pulse_fs();
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", ifc.busy, 1'b0);
    check("abort_x", ifc.x_all, '0);
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (ifc.done) dcnt++;
      @(negedge clk);
    end
    check("abort_no_done", dcnt, 0);

    // Free-running random traffic, including overlapping frame_start and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      rand_cfg();
      ifc.frame_start = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    ifc.cfg_we = 1'b0; ifc.frame_start = 1'b0; reset = 1'b0;
    repeat (30) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
